// File: rtl/fetch_controller.sv
// Instruction-fetch front end: drives PCNext for the program counter, issues
// one imem read per PC, and presents fetched words to decode.
module fetch_controller #(
  parameter int unsigned         WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int unsigned         PC_STEP   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] PC,
  output logic [WORD_SIZE-1:0] PCNext,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  output logic                 instr_valid,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] instr_pc,
  input  logic                 decode_ready,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_target
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(PC_STEP);

  state_t               state, state_next;
  logic [WORD_SIZE-1:0] addr_q;
  logic                 req_pending;
  logic                 slot_free;
  logic                 xfer;
  logic                 ack;
  logic                 capture;

  assign slot_free = !instr_valid || decode_ready;
  assign xfer      = instr_valid && decode_ready;
  assign ack       = imem_req && imem_ack;
  assign capture   = (state == FETCH) && ack && !redirect;

  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = PC;
    PCNext     = PC;
    state_next = state;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = slot_free || req_pending;
        if (capture) PCNext = PC + STEP;
        if (redirect) state_next = (imem_req && !imem_ack) ? DISCARD : FETCH;
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_ack && !redirect) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) PCNext = redirect_target;
    // Reset overrides every other input, including an in-flight request.
    if (rst) begin
      imem_req = 1'b0;
      PCNext   = RESET_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      addr_q      <= '0;
      req_pending <= 1'b0;
    end else begin
      state       <= state_next;
      req_pending <= (state_next == FETCH) && imem_req && !imem_ack;
      if (state == FETCH) addr_q <= PC;
      if (redirect) begin
        instr_valid <= 1'b0;
      end else if (capture) begin
        instr       <= imem_rdata;
        instr_pc    <= PC;
        instr_valid <= 1'b1;
      end else if (xfer) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; the bench closes the PC loop with its
// own program counter register and plays the memory side by hand.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        redirect;
  logic [31:0] redirect_target;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) pc <= pc_next;

  fetch_controller #(.WORD_SIZE(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .PC(pc), .PCNext(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .decode_ready(decode_ready), .redirect(redirect),
    .redirect_target(redirect_target)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] rd,
                       input logic dr, input logic rdir, input logic [31:0] tgt);
    rst = r; imem_ack = a; imem_rdata = rd; decode_ready = dr;
    redirect = rdir; redirect_target = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic req, input logic [31:0] addr,
                          input logic [31:0] nxt);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".pcnext"}, pc_next, nxt);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] ipc);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
    chk({tag, ".instr"}, instr, ins);
    chk({tag, ".instr_pc"}, instr_pc, ipc);
  endtask

  initial begin
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    // Reset: two cycles, ack high to confirm it is ignored
    drive(1, 1, 32'h1234_5678, 1, 0, 32'h0);
    chk_comb("rst0", 0, 32'h0, 32'h0);
    tick();
    chk_comb("rst1", 0, 32'h0, 32'h0);
    tick();
    chk_out("rst_state", 0, 32'h0, 32'h0);
    chk("rst_pc", pc, 32'h0);

    // IDLE cycle
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk_comb("idle", 0, 32'h0, 32'h0);
    tick();

    // Zero-wait fetches at 0x0 and 0x4
    drive(0, 1, 32'hC0DE_0000, 1, 0, 32'h0);
    chk_comb("zw0", 1, 32'h0, 32'h4);
    tick();
    chk_out("zw0", 1, 32'hC0DE_0000, 32'h0);
    drive(0, 1, 32'hC0DE_0004, 1, 0, 32'h0);
    chk_comb("zw1", 1, 32'h4, 32'h8);
    tick();
    chk_out("zw1", 1, 32'hC0DE_0004, 32'h4);

    // Decode backpressure: no request, PC holds, stray ack ignored
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 32'hBAD0_0000, 0, 0, 32'h0);
      chk_comb("stall", 0, 32'h8, 32'h8);
      tick();
      chk_out("stall", 1, 32'hC0DE_0004, 32'h4);
    end

    // Delayed ack at 0x8: three waiting cycles, then ack
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, (i == 1) ? 1'b0 : 1'b1, 0, 32'h0);
      chk_comb("wait8", 1, 32'h8, 32'h8);
      tick();
    end
    chk("wait8.valid_cleared", {31'd0, instr_valid}, 32'd0);
    drive(0, 1, 32'hC0DE_0008, 1, 0, 32'h0);
    chk_comb("ack8", 1, 32'h8, 32'hC);
    tick();
    chk_out("ack8", 1, 32'hC0DE_0008, 32'h8);

    // Fetch 0xC, then leave 0x10 unacked and redirect to 0x100
    drive(0, 1, 32'hC0DE_000C, 1, 0, 32'h0);
    chk_comb("ackC", 1, 32'hC, 32'h10);
    tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk_comb("wait10", 1, 32'h10, 32'h10);
    tick();
    drive(0, 0, 32'h0, 1, 1, 32'h100);
    chk_comb("redir", 1, 32'h10, 32'h100);
    tick();
    chk("redir.valid", {31'd0, instr_valid}, 32'd0);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk_comb("discard_wait", 1, 32'h10, 32'h100);
    tick();
    drive(0, 1, 32'hDEAD_0010, 1, 0, 32'h0);
    chk_comb("discard_ack", 1, 32'h10, 32'h100);
    tick();
    chk_out("discard_drop", 0, 32'hC0DE_000C, 32'hC);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk_comb("post_discard", 1, 32'h100, 32'h100);
    tick();
    drive(0, 1, 32'hC0DE_0100, 1, 0, 32'h0);
    chk_comb("ack100", 1, 32'h100, 32'h104);
    tick();
    chk_out("ack100", 1, 32'hC0DE_0100, 32'h100);

    // Redirect with no request outstanding clears valid despite decode_ready=0
    drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    chk_comb("redir_idle", 0, 32'h0, 32'hFFFF_FFFC);
    tick();
    chk("redir_idle.valid", {31'd0, instr_valid}, 32'd0);

    // Wrap at the top of the address space
    drive(0, 1, 32'hC0DE_FFFC, 1, 0, 32'h0);
    chk_comb("wrap", 1, 32'hFFFF_FFFC, 32'h0);
    tick();
    chk_out("wrap", 1, 32'hC0DE_FFFC, 32'hFFFF_FFFC);

    // Redirect coinciding with ack: data dropped, stay in FETCH
    drive(0, 1, 32'hBAD0_0000, 1, 1, 32'h200);
    chk_comb("redir_ack", 1, 32'h0, 32'h200);
    tick();
    chk_out("redir_ack", 0, 32'hC0DE_FFFC, 32'hFFFF_FFFC);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk_comb("after_redir_ack", 1, 32'h200, 32'h200);
    tick();

    // Reset while a request is outstanding
    drive(1, 1, 32'hBAD0_0001, 1, 0, 32'h0);
    chk_comb("rst_mid", 0, 32'h0, 32'h0);
    tick();
    chk_out("rst_mid", 0, 32'h0, 32'h0);
    drive(0, 1, 32'hBAD0_0002, 1, 0, 32'h0);
    chk_comb("rst_mid_idle", 0, 32'h0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
